// File: rtl/alu_issue_arbiter_pkg.sv
// Shared backend definitions: ALU op encoding, datapath widths and request record.
package alu_issue_arbiter_pkg;

  localparam int ALU_OP_W  = 14;
  localparam int XLEN      = 32;
  localparam int MAX_TAG_W = 16;

  // One-hot op bit positions; bits 12 and 13 are reserved.
  localparam int OP_ADD  = 0;
  localparam int OP_PASS = 1;
  localparam int OP_OR   = 2;
  localparam int OP_SUB  = 3;
  localparam int OP_XOR  = 4;
  localparam int OP_SRA  = 5;
  localparam int OP_AND  = 6;
  localparam int OP_SLL  = 7;
  localparam int OP_SRL  = 8;
  localparam int OP_SLTU = 9;
  localparam int OP_NOR  = 10;
  localparam int OP_SLT  = 11;

  // Tag field is sized for the widest tag any arbiter instance uses.
  typedef struct packed {
    logic [ALU_OP_W-1:0]  op;
    logic [XLEN-1:0]      src1;
    logic [XLEN-1:0]      src2;
    logic [MAX_TAG_W-1:0] tag;
  } alu_req_t;

endpackage

// File: rtl/alu_issue_arbiter_alu.sv
// Single-cycle combinational integer ALU with one-hot op select.
module alu
  import alu_issue_arbiter_pkg::*;
(
  input  logic [ALU_OP_W-1:0] op,
  input  logic [XLEN-1:0]     src1,
  input  logic [XLEN-1:0]     src2,
  output logic [XLEN-1:0]     result
);

  logic [4:0] shamt;
  logic       reserved_unused;

  assign shamt           = src2[4:0];
  assign reserved_unused = |op[13:12];

  // OR together every selected function; a legal one-hot op selects exactly one.
  always_comb begin
    result = '0;
    if (op[OP_ADD])  result = result | (src1 + src2);
    if (op[OP_PASS]) result = result | src1;
    if (op[OP_OR])   result = result | (src1 | src2);
    if (op[OP_SUB])  result = result | (src1 - src2);
    if (op[OP_XOR])  result = result | (src1 ^ src2);
    if (op[OP_SRA])  result = result | XLEN'($signed(src1) >>> shamt);
    if (op[OP_AND])  result = result | (src1 & src2);
    if (op[OP_SLL])  result = result | (src1 << shamt);
    if (op[OP_SRL])  result = result | (src1 >> shamt);
    if (op[OP_SLTU]) result = result | XLEN'(src1 < src2);
    if (op[OP_NOR])  result = result | ~(src1 | src2);
    if (op[OP_SLT])  result = result | XLEN'($signed(src1) < $signed(src2));
  end

endmodule

// File: rtl/alu_issue_arbiter_rr_pick.sv
// Round-robin picker: first valid requester at or above ptr, wrapping modulo NREQ.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [ID_W-1:0] ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant_onehot,
  output logic [ID_W-1:0] grant_idx
);

  // Scan NREQ positions starting at ptr; the first valid one wins.
  always_comb begin
    int unsigned idx;
    logic        found;
    grant_onehot = '0;
    grant_idx    = '0;
    found        = 1'b0;
    idx          = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr) + k) % NREQ;
      if (en && !found && valid[idx]) begin
        found             = 1'b1;
        grant_onehot[idx] = 1'b1;
        grant_idx         = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Shares one ALU among NREQ issue requesters; result held in a valid/ready output slot.
module alu_issue_arbiter
  import alu_issue_arbiter_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int TAG_W = 4,
  parameter int ID_W  = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*ALU_OP_W-1:0] req_op,
  input  logic [NREQ*XLEN-1:0]     req_src1,
  input  logic [NREQ*XLEN-1:0]     req_src2,
  input  logic [NREQ*TAG_W-1:0]    req_tag,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [XLEN-1:0]          rsp_result,
  output logic [ID_W-1:0]          rsp_id,
  output logic [TAG_W-1:0]         rsp_tag
);

  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] ptr_next;
  logic [NREQ-1:0] grant_onehot;
  logic [ID_W-1:0] grant_idx;
  logic            slot_free;
  logic            pick_en;
  logic            handshake;
  alu_req_t        sel;
  logic [XLEN-1:0] alu_result;
  logic            tag_unused;

  assign slot_free = !rsp_valid || rsp_ready;
  // rst_n gates the picker so nothing is granted during the reset cycle.
  assign pick_en   = rst_n && !flush && slot_free;

  rr_pick #(.NREQ(NREQ), .ID_W(ID_W)) u_pick (
    .valid        (req_valid),
    .ptr          (rr_ptr),
    .en           (pick_en),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx)
  );

  assign req_ready  = grant_onehot;
  assign handshake  = |(req_valid & req_ready);
  assign ptr_next   = (grant_idx == ID_W'(NREQ - 1)) ? '0 : grant_idx + ID_W'(1);
  assign tag_unused = |(sel.tag >> TAG_W);

  // Route the granted requester's slice to the ALU; zeros when idle.
  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_onehot[i]) begin
        sel.op   = req_op[ALU_OP_W*i +: ALU_OP_W];
        sel.src1 = req_src1[XLEN*i +: XLEN];
        sel.src2 = req_src2[XLEN*i +: XLEN];
        sel.tag  = MAX_TAG_W'(req_tag[TAG_W*i +: TAG_W]);
      end
    end
  end

  alu u_alu (
    .op     (sel.op),
    .src1   (sel.src1),
    .src2   (sel.src2),
    .result (alu_result)
  );

  // Output slot and round-robin pointer; flush never coincides with a grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_id     <= '0;
      rsp_tag    <= '0;
      rr_ptr     <= '0;
    end else if (flush) begin
      rsp_valid <= 1'b0;
    end else if (handshake) begin
      rsp_valid  <= 1'b1;
      rsp_result <= alu_result;
      rsp_id     <= grant_idx;
      rsp_tag    <= sel.tag[TAG_W-1:0];
      rr_ptr     <= ptr_next;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule
